// File: rtl/piso_sipo_pkg.sv
// Constants and hold-state encoding shared by the piso/sipo serialiser pair.
package piso_sipo_pkg;

   localparam int WORD_W = 16;
   localparam int SYM_W  = 2;
   localparam int NSYM   = WORD_W / SYM_W;
   localparam int CNT_W  = $clog2(NSYM);

   typedef enum logic {
      H_EMPTY = 1'b0,
      H_FULL  = 1'b1
   } hold_state_e;

endpackage

// File: rtl/sipo.sv
// Serial-in/parallel-out packer: gathers SYM_W-bit symbols into WORD_W words and
// feeds them to a FIFO through a one-word holding register.
module sipo
   import piso_sipo_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [SYM_W-1:0]  data_serial_i,
   input  logic              valid_serial_i,
   input  logic              flush_i,
   output logic [WORD_W-1:0] fifo_data_o,
   output logic              fifo_wr_en_o,
   input  logic              fifo_full_i,
   output logic              overflow_o,
   output logic              ready_serial_o
);

   logic [WORD_W-1:0] shift_q, shift_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [WORD_W-1:0] hold_q, hold_d;
   hold_state_e       state_q, state_d;
   logic              overflow_q, overflow_d;

   logic [WORD_W-1:0] shifted;
   logic [WORD_W-1:0] cur_word;
   logic [WORD_W-1:0] new_word;
   logic [CNT_W:0]    cur_cnt;
   int                pad_bits;
   logic              wrap;
   logic              do_flush;
   logic              complete;
   logic              pop;

   // A symbol arriving with flush is absorbed first, so the flush sees the updated count.
   always_comb begin
      shifted  = {shift_q[WORD_W-SYM_W-1:0], data_serial_i};
      wrap     = valid_serial_i && (cnt_q == CNT_W'(NSYM-1));
      cur_word = valid_serial_i ? shifted : shift_q;
      cur_cnt  = valid_serial_i ? ({1'b0, cnt_q} + 1'b1) : {1'b0, cnt_q};
      do_flush = flush_i && !wrap && (cur_cnt != '0);
      complete = wrap || do_flush;
      pad_bits = SYM_W * (NSYM - int'(cur_cnt));
      new_word = wrap ? shifted : (cur_word << pad_bits);
      shift_d  = cur_word;
      cnt_d    = complete ? '0 : cur_cnt[CNT_W-1:0];
   end

   always_comb begin
      pop        = (state_q == H_FULL) && !fifo_full_i;
      state_d    = state_q;
      hold_d     = hold_q;
      overflow_d = overflow_q;
      case (state_q)
         H_EMPTY: begin
            if (complete) begin
               hold_d  = new_word;
               state_d = H_FULL;
            end
         end
         H_FULL: begin
            if (pop) begin
               if (complete) begin
                  hold_d = new_word;
               end else begin
                  state_d = H_EMPTY;
               end
            end else if (complete) begin
               overflow_d = 1'b1;
            end
         end
         default: state_d = H_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q    <= '0;
         cnt_q      <= '0;
         hold_q     <= '0;
         state_q    <= H_EMPTY;
         overflow_q <= 1'b0;
      end else begin
         shift_q    <= shift_d;
         cnt_q      <= cnt_d;
         hold_q     <= hold_d;
         state_q    <= state_d;
         overflow_q <= overflow_d;
      end
   end

   assign fifo_data_o    = hold_q;
   assign fifo_wr_en_o   = pop;
   assign overflow_o     = overflow_q;
   assign ready_serial_o = !((state_q == H_FULL) && fifo_full_i && (cnt_q == CNT_W'(NSYM-1)));

endmodule

// File: tb/tb_sipo.sv
// Self-checking bench for sipo: constant vector table, directed corner sequences
// and a randomized run against a symbol-queue reference model.
module tb_sipo;
   import piso_sipo_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [SYM_W-1:0]  data_serial_i = '0;
   logic              valid_serial_i = 1'b0;
   logic              flush_i = 1'b0;
   logic [WORD_W-1:0] fifo_data_o;
   logic              fifo_wr_en_o;
   logic              fifo_full_i = 1'b0;
   logic              overflow_o;
   logic              ready_serial_o;

   always #5 clk = ~clk;

   sipo dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .data_serial_i  (data_serial_i),
      .valid_serial_i (valid_serial_i),
      .flush_i        (flush_i),
      .fifo_data_o    (fifo_data_o),
      .fifo_wr_en_o   (fifo_wr_en_o),
      .fifo_full_i    (fifo_full_i),
      .overflow_o     (overflow_o),
      .ready_serial_o (ready_serial_o)
   );

   int total = 0;
   int bad   = 0;

   int          m_syms[$];
   bit          m_hold_v;
   logic [15:0] m_hold_w;
   bit          m_ovf;

   logic [15:0] dut_writes[$];
   logic        s_wr, s_ready, s_ovf;
   logic [15:0] s_data;

   typedef struct {
      bit          v;
      bit [1:0]    s;
      bit          f;
      bit          full;
      bit          exp_wr;
      logic [15:0] exp_data;
      bit          exp_ovf;
      bit          exp_ready;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [15:0] pack(input int q[$]);
      int w = 0;
      for (int i = 0; i < NSYM; i++)
         w = w * 4 + ((i < q.size()) ? q[i] : 0);
      return 16'(w);
   endfunction

   function automatic vec_t mk(bit v, bit [1:0] s, bit f, bit full, bit wr, logic [15:0] d, bit ovf, bit rdy);
      vec_t r;
      r.v = v; r.s = s; r.f = f; r.full = full;
      r.exp_wr = wr; r.exp_data = d; r.exp_ovf = ovf; r.exp_ready = rdy;
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs, compare outputs with the model, then advance both by one edge.
   task automatic applyStimulus(input bit v, input bit [1:0] s, input bit f, input bit full);
      bit          exp_wr;
      bit          complete;
      logic [15:0] word;
      valid_serial_i = v;
      data_serial_i  = s;
      flush_i        = f;
      fifo_full_i    = full;
      #1;
      s_wr    = fifo_wr_en_o;
      s_data  = fifo_data_o;
      s_ovf   = overflow_o;
      s_ready = ready_serial_o;
      if (s_wr === 1'b1) dut_writes.push_back(s_data);
      exp_wr = m_hold_v && !full;
      checkOutput("model wr_en", {31'd0, s_wr}, {31'd0, exp_wr});
      if (exp_wr) checkOutput("model data", {16'd0, s_data}, {16'd0, m_hold_w});
      checkOutput("model overflow", {31'd0, s_ovf}, {31'd0, m_ovf});
      checkOutput("model ready", {31'd0, s_ready},
                  {31'd0, !(m_hold_v && full && m_syms.size() == NSYM-1)});
      @(posedge clk);
      complete = 1'b0;
      word     = '0;
      if (v) begin
         m_syms.push_back(int'(s));
         if (m_syms.size() == NSYM) begin
            word = pack(m_syms);
            m_syms.delete();
            complete = 1'b1;
         end
      end
      if (!complete && f && m_syms.size() > 0) begin
         word = pack(m_syms);
         m_syms.delete();
         complete = 1'b1;
      end
      if (complete) begin
         if (!m_hold_v || exp_wr) begin
            m_hold_w = word;
            m_hold_v = 1'b1;
         end else begin
            m_ovf = 1'b1;
         end
      end else if (exp_wr) begin
         m_hold_v = 1'b0;
      end
      #1;
   endtask

   task automatic doReset();
      rst_n          = 1'b0;
      valid_serial_i = 1'b0;
      flush_i        = 1'b0;
      fifo_full_i    = 1'b0;
      #2;
      checkOutput("reset wr_en", {31'd0, fifo_wr_en_o}, 32'd0);
      checkOutput("reset data", {16'd0, fifo_data_o}, 32'd0);
      checkOutput("reset overflow", {31'd0, overflow_o}, 32'd0);
      checkOutput("reset ready", {31'd0, ready_serial_o}, 32'd1);
      m_syms.delete();
      m_hold_v = 1'b0;
      m_hold_w = '0;
      m_ovf    = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic sendWord(input logic [15:0] w, input bit full);
      for (int i = 0; i < NSYM; i++)
         applyStimulus(1'b1, w[15-2*i -: 2], 1'b0, full);
   endtask

   initial begin
      doReset();

      // 8x "10" -> AAAA, then "11,01,10"+flush -> D800, then 8x "00" -> 0000
      for (int i = 0; i < 8; i++) vecs.push_back(mk(1, 2'b10, 0, 0, 0, 16'h0000, 0, 1));
      vecs.push_back(mk(0, 2'b00, 0, 0, 1, 16'hAAAA, 0, 1));
      vecs.push_back(mk(0, 2'b00, 0, 0, 0, 16'h0000, 0, 1));
      vecs.push_back(mk(1, 2'b11, 0, 0, 0, 16'h0000, 0, 1));
      vecs.push_back(mk(1, 2'b01, 0, 0, 0, 16'h0000, 0, 1));
      vecs.push_back(mk(1, 2'b10, 0, 0, 0, 16'h0000, 0, 1));
      vecs.push_back(mk(0, 2'b00, 1, 0, 0, 16'h0000, 0, 1));
      vecs.push_back(mk(0, 2'b00, 0, 0, 1, 16'hD800, 0, 1));
      for (int i = 0; i < 8; i++) vecs.push_back(mk(1, 2'b00, 0, 0, 0, 16'h0000, 0, 1));
      vecs.push_back(mk(0, 2'b00, 0, 0, 1, 16'h0000, 0, 1));
      vecs.push_back(mk(0, 2'b00, 0, 0, 0, 16'h0000, 0, 1));
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].v, vecs[i].s, vecs[i].f, vecs[i].full);
         checkOutput("table wr_en", {31'd0, s_wr}, {31'd0, vecs[i].exp_wr});
         if (vecs[i].exp_wr) checkOutput("table data", {16'd0, s_data}, {16'd0, vecs[i].exp_data});
         checkOutput("table overflow", {31'd0, s_ovf}, {31'd0, vecs[i].exp_ovf});
         checkOutput("table ready", {31'd0, s_ready}, {31'd0, vecs[i].exp_ready});
      end

      dut_writes.delete();
      sendWord(16'h5555, 1'b0);
      sendWord(16'hFFFF, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
      checkOutput("b2b write count", 32'(dut_writes.size()), 32'd2);
      if (dut_writes.size() >= 2) begin
         checkOutput("b2b word0", {16'd0, dut_writes[0]}, 32'h5555);
         checkOutput("b2b word1", {16'd0, dut_writes[1]}, 32'hFFFF);
      end
      checkOutput("b2b overflow", {31'd0, overflow_o}, 32'd0);

      dut_writes.delete();
      sendWord(16'h1234, 1'b1);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 2'b00, 1'b0, 1'b1);
      checkOutput("stall held data", {16'd0, s_data}, 32'h1234);
      checkOutput("stall no writes", 32'(dut_writes.size()), 32'd0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
      checkOutput("stall write count", 32'(dut_writes.size()), 32'd1);
      if (dut_writes.size() >= 1)
         checkOutput("stall word", {16'd0, dut_writes[0]}, 32'h1234);

      dut_writes.delete();
      sendWord(16'h0F0F, 1'b1);
      for (int i = 0; i < NSYM; i++) begin
         logic [15:0] w2;
         w2 = 16'hF0F0;
         applyStimulus(1'b1, w2[15-2*i -: 2], 1'b0, 1'b1);
         if (i == NSYM-1) checkOutput("ovf ready slot8", {31'd0, s_ready}, 32'd0);
      end
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b1);
      checkOutput("ovf sticky", {31'd0, s_ovf}, 32'd1);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
      checkOutput("ovf write count", 32'(dut_writes.size()), 32'd1);
      if (dut_writes.size() >= 1)
         checkOutput("ovf kept word", {16'd0, dut_writes[0]}, 32'h0F0F);

      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 2'($urandom_range(3)), 1'b0, 1'b0);
      doReset();
      dut_writes.delete();
      sendWord(16'hC3A5, 1'b0);
      for (int i = 0; i < 2; i++) applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
      checkOutput("post-reset write count", 32'(dut_writes.size()), 32'd1);
      if (dut_writes.size() >= 1)
         checkOutput("post-reset word", {16'd0, dut_writes[0]}, 32'hC3A5);

      for (int i = 0; i < 400; i++)
         applyStimulus($urandom_range(3) != 0, 2'($urandom_range(3)),
                       $urandom_range(19) == 0, $urandom_range(9) < 3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
